window_4x4: RTL and testbench
=============================

Name: window_4x4

Overview:
- Consumes the per-column 4-row taps of the line buffer stage and assembles a sliding 4x4 pixel window for the bicubic interpolation core.
- Realigns the line buffer's combinational newest-row tap against its registered older-row taps.
- Tracks window coordinates and flags only windows lying fully inside the image.
- Sits between the line buffer and the interpolator; one instance per colour plane.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 128, pixels per line; must match the line buffer; minimum 4.
- IMG_HEIGHT, 128, lines per frame; minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  pixel strobe, identical to the line buffer's ce.
- sof  in  1  start of frame; qualified by ce; marks pixel (0,0).
- flush  in  1  one-cycle pulse after the last pixel of a frame; advances the pipeline without a new pixel.
- tap_0  in  DATA_WIDTH  newest row; combinational, belongs to the current ce.
- tap_1, tap_2, tap_3  in  DATA_WIDTH each  rows -1..-3; registered, belong to the previous ce.
- win  out  16*DATA_WIDTH  window. Element (r,c) sits at bits [(r*4+c)*DATA_WIDTH +: DATA_WIDTH]. r=0 is the oldest row, c=0 the leftmost column.
- win_valid  out  1  one-cycle pulse; win, win_x and win_y are meaningful.
- win_x  out  $clog2(IMG_WIDTH)  image column of window element (·,0).
- win_y  out  $clog2(IMG_HEIGHT)  image row of window element (0,·).
- frame_done  out  1  one-cycle pulse after the last window of a frame.

Behaviour:
- Reset (rst=0, async): all outputs 0; window registers, hold register and counters cleared; state IDLE.
- Alignment: on each advance, the hold register h0 <= tap_0. The aligned column is {tap_3, tap_2, tap_1, h0} (oldest..newest). It belongs to the pixel of the previous advance.
- Advance = ce, or flush while in ACTIVE. If ce and flush are both high, ce wins and flush is ignored.
- On an advance: the window shifts left by one column and the aligned column enters at c=3. Counters (xa, ya) give the aligned pixel position, wrap at IMG_WIDTH-1, and ya increments on wrap.
- States:
  - IDLE: waits for ce&sof. Loads h0, sets pending=1 and xa=ya=0, goes to ACTIVE. No window is emitted from this first ce.
  - ACTIVE: every advance consumes the pending aligned pixel at (xa, ya). win_valid is registered, so it is high the cycle after the shift, when xa>=3 and ya>=3. Then win_x=xa-3 and win_y=ya-3. Windows at xa<3 mix columns of the previous line and are suppressed. Rows ya<3 contain unflushed line-buffer data and are suppressed.
  - DONE: entered when the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is consumed. frame_done pulses the same cycle as that final win_valid. The state returns to IDLE the next cycle.
- ce&sof while in ACTIVE (early restart): abandon the frame, emit no window for the pending pixel, reload h0, zero the counters, stay in ACTIVE.
- ce without sof in IDLE or DONE: ignored.
- flush in IDLE or DONE: ignored.
- Ports are sized by $clog2; no arithmetic overflow is possible within the parameter limits.
- Windows per frame: (IMG_WIDTH-3)*(IMG_HEIGHT-3).
- Latency: a window is valid 1 cycle after the advance that shifts in its rightmost column. With continuous ce, that column is the pixel 2 ce earlier.

Optional Feature:
- Macro WIN_FRAME_STATS_EN.
- Defined: adds output win_count, 16 bits. It counts win_valid pulses in the current frame, saturating at 16'hFFFF, and clears on reset and on ce&sof. Its value at frame_done equals (W-3)*(H-3).
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package upscaler_pkg holds:
  - constant WIN_SIZE = 4;
  - the state enum typedef {IDLE, ACTIVE, DONE};
  - a pixel typedef of DATA_WIDTH bits;
  - the win bit-packing index helper.
- One sub-module: window_shift_reg, a 4x4 register array with a shift enable and a 4-pixel column input. The parent owns counters, alignment, the FSM and valid generation.

Test Plan (W=8, H=6; pixel value = y*16+x, fed through a line_buffer instance):
- Full frame, continuous ce, flush after the last pixel -> exactly 15 win_valid pulses. The first has win_x=0, win_y=0 and win (0,0)=8'h00, (3,3)=8'h33. The last has win_x=4, win_y=2, (3,3)=8'h57. frame_done coincides with the last pulse.
- ce toggled 1-0-1 randomly across the frame -> the same 15 windows with identical contents and coordinates; no extra pulses.
- Line-wrap check -> no win_valid for xa=0..2 on any row. The window at win_x=0, win_y=1 has (0,0)=8'h10, (3,3)=8'h43.
- ce&sof reasserted at pixel (5,4) mid-frame, then a full frame -> the abandoned frame yields no frame_done; the new frame yields 15 windows.
- rst driven low for 1 cycle mid-frame at (2,3) -> all outputs 0 immediately (async). Subsequent pixels without sof are ignored until ce&sof.
- flush together with ce, and flush in IDLE -> flush ignored in both cases; window count and contents are unchanged.

Source files
------------

// File: rtl/upscaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upscaler_pkg
// Description : Shared types and helpers for the 4x4 window stage of the
//               bicubic upscaler (window size, FSM state type, pixel type and
//               the bit-packing index helper for the flattened window bus).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package upscaler_pkg;

  localparam int WIN_SIZE    = 4;
  localparam int PIXEL_WIDTH = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // LSB position of window element (row, col) in the flattened window bus.
  // Row 0 is the oldest line, column 0 the leftmost pixel.
  function automatic int win_lsb(input int row, input int col, input int width);
    return (row * WIN_SIZE + col) * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_4x4_if.sv
`default_nettype none
// ============================================================================
// Module      : window_4x4_if
// Description : Bundle between the line buffer / pixel source and the 4x4
//               window assembler.
//               master : pixel source side (drives ce/sof/flush/taps)
//               slave  : window_4x4 side (drives the window outputs)
// Signals     : ce, sof, flush, tap_0..tap_3 (towards window_4x4)
//               win, win_valid, win_x, win_y, frame_done (from window_4x4)
//               win_count (only when WIN_FRAME_STATS_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
interface window_4x4_if
  import upscaler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
);

  logic                                     ce;
  logic                                     sof;
  logic                                     flush;
  logic [DATA_WIDTH-1:0]                    tap_0;
  logic [DATA_WIDTH-1:0]                    tap_1;
  logic [DATA_WIDTH-1:0]                    tap_2;
  logic [DATA_WIDTH-1:0]                    tap_3;
  logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0]  win;
  logic                                     win_valid;
  logic [$clog2(IMG_WIDTH)-1:0]             win_x;
  logic [$clog2(IMG_HEIGHT)-1:0]            win_y;
  logic                                     frame_done;
`ifdef WIN_FRAME_STATS_EN
  logic [15:0]                              win_count;
`endif

  modport master (
    output ce, sof, flush, tap_0, tap_1, tap_2, tap_3,
    input  win, win_valid, win_x, win_y, frame_done
`ifdef WIN_FRAME_STATS_EN
    , input win_count
`endif
  );

  modport slave (
    input  ce, sof, flush, tap_0, tap_1, tap_2, tap_3,
    output win, win_valid, win_x, win_y, frame_done
`ifdef WIN_FRAME_STATS_EN
    , output win_count
`endif
  );

endinterface
`default_nettype wire

// File: rtl/window_4x4_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : window_shift_reg
// Description : 4x4 pixel register array. On shift_en every row moves one
//               column to the left and col_in enters at the rightmost column.
// Ports       : clk      - clock
//               rst      - asynchronous active-low reset
//               shift_en - shift the window by one column
//               col_in   - new column, row r at [r*DATA_WIDTH +: DATA_WIDTH],
//                          row 0 = oldest line
//               win      - flattened window, element (r,c) at win_lsb(r,c)
// Revision    : 1.0 - initial release
// ============================================================================
module window_shift_reg
  import upscaler_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                                    clk,
  input  wire logic                                    rst,
  input  wire logic                                    shift_en,
  input  wire logic [WIN_SIZE*DATA_WIDTH-1:0]          col_in,
  output logic      [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] win
);

  logic [DATA_WIDTH-1:0] r_cell [WIN_SIZE][WIN_SIZE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE; c++) begin
          r_cell[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE - 1; c++) begin
          r_cell[r][c] <= r_cell[r][c+1];
        end
        r_cell[r][WIN_SIZE-1] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar r = 0; r < WIN_SIZE; r++) begin : g_row
    for (genvar c = 0; c < WIN_SIZE; c++) begin : g_col
      assign win[win_lsb(r, c, DATA_WIDTH) +: DATA_WIDTH] = r_cell[r][c];
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_4x4.sv
`default_nettype none
// ============================================================================
// Module      : window_4x4
// Description : Assembles a sliding 4x4 pixel window from the line buffer's
//               per-column taps, realigning the combinational newest-row tap
//               against the registered older rows, tracking window position
//               and flagging only windows lying fully inside the image.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset
//               bus  - window_4x4_if.slave:
//                      in : ce, sof, flush, tap_0..tap_3
//                      out: win, win_valid, win_x, win_y, frame_done
//                           win_count (WIN_FRAME_STATS_EN only)
// Options     : WIN_FRAME_STATS_EN - adds a saturating 16-bit per-frame
//               window counter on bus.win_count.
// Revision    : 1.0 - initial release
// ============================================================================
module window_4x4
  import upscaler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  wire logic   clk,
  input  wire logic   rst,
  window_4x4_if.slave bus
);

  localparam int c_xw = $clog2(IMG_WIDTH);
  localparam int c_yw = $clog2(IMG_HEIGHT);
  localparam logic [c_xw-1:0] c_x_last = c_xw'(IMG_WIDTH - 1);
  localparam logic [c_yw-1:0] c_y_last = c_yw'(IMG_HEIGHT - 1);
  localparam logic [c_xw-1:0] c_x_edge = c_xw'(WIN_SIZE - 1);
  localparam logic [c_yw-1:0] c_y_edge = c_yw'(WIN_SIZE - 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_h0;
  logic                    r_pending;
  logic [c_xw-1:0]         r_xa;
  logic [c_yw-1:0]         r_ya;
  logic                    r_win_valid;
  logic                    r_frame_done;
  logic [c_xw-1:0]         r_win_x;
  logic [c_yw-1:0]         r_win_y;

  logic                    w_active;
  logic                    w_start;
  logic                    w_advance;
  logic                    w_consume;
  logic                    w_last;
  logic                    w_emit;
  logic [WIN_SIZE*DATA_WIDTH-1:0] w_col;
  logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] w_win;

  assign w_active  = (r_state == ACTIVE);
  assign w_start   = bus.ce & bus.sof;
  // flush only moves the pipeline while a frame is in progress; ce wins
  assign w_advance = bus.ce | (bus.flush & w_active);
  // a start-of-frame abandons the pending pixel instead of consuming it
  assign w_consume = w_active & w_advance & r_pending & ~w_start;
  assign w_last    = (r_xa == c_x_last) && (r_ya == c_y_last);
  // windows with xa<3 straddle a line wrap, rows ya<3 hold stale lines
  assign w_emit    = w_consume && (r_xa >= c_x_edge) && (r_ya >= c_y_edge);

  // h0 holds the newest-row pixel of the previous advance so it lines up
  // with the registered taps, which also belong to the previous advance.
  assign w_col = {r_h0, bus.tap_1, bus.tap_2, bus.tap_3};

  window_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_consume),
    .col_in   (w_col),
    .win      (w_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_h0         <= '0;
      r_pending    <= 1'b0;
      r_xa         <= '0;
      r_ya         <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_h0      <= bus.tap_0;
            r_pending <= 1'b1;
            r_xa      <= '0;
            r_ya      <= '0;
            r_state   <= ACTIVE;
          end else if (r_state == DONE) begin
            r_state   <= IDLE;
          end
        end
        ACTIVE: begin
          if (w_start) begin
            r_h0      <= bus.tap_0;
            r_pending <= 1'b1;
            r_xa      <= '0;
            r_ya      <= '0;
          end else if (w_advance) begin
            if (r_pending) begin
              r_win_valid <= w_emit;
              if (w_emit) begin
                r_win_x <= r_xa - c_x_edge;
                r_win_y <= r_ya - c_y_edge;
              end
              if (w_last) begin
                r_frame_done <= 1'b1;
                r_state      <= DONE;
              end else if (r_xa == c_x_last) begin
                r_xa <= '0;
                r_ya <= r_ya + 1'b1;
              end else begin
                r_xa <= r_xa + 1'b1;
              end
            end
            // a flush-only advance brings no new pixel; a ce after the final
            // pixel belongs to no frame
            if (bus.ce) begin
              r_h0 <= bus.tap_0;
            end
            r_pending <= bus.ce & ~(r_pending & w_last);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef WIN_FRAME_STATS_EN
  logic [15:0] r_win_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_count <= '0;
    end else if (w_start) begin
      r_win_count <= '0;
    end else if (w_emit && (r_win_count != 16'hFFFF)) begin
      r_win_count <= r_win_count + 16'd1;
    end
  end

  assign bus.win_count = r_win_count;
`endif

  assign bus.win        = w_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_x      = r_win_x;
  assign bus.win_y      = r_win_y;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_window_4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_4x4
// Description : Scoreboard bench for window_4x4 (W=8, H=6). A small line
//               buffer model feeds the taps; expected windows are derived
//               from the frame contents and queued when a frame is issued,
//               and a monitor pops and compares on every win_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_4x4;
  import upscaler_pkg::*;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WB = WIN_SIZE * WIN_SIZE * DW;

  typedef struct {
    logic [WB-1:0] win;
    int            x;
    int            y;
    bit            last;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     total = 0;
  int     bad = 0;
  int     n_valid = 0;
  int     n_done = 0;
  int     lb_x = 0;
  exp_t   q[$];
  pixel_t frame [H][W];
  pixel_t lb_line [3][W];

  bit            cap_en = 1'b0;
  bit            have_first = 1'b0;
  logic [WB-1:0] cap_first, cap_last, cap_wrap;
  int            cap_last_x, cap_last_y;

  window_4x4_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  window_4x4 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Line buffer: tap_0 is the live pixel, tap_k the pixel k lines above,
  // registered on the ce that presented the column.
  always @(posedge clk) begin
    if (bus.ce) begin
      bus.tap_1        <= lb_line[0][lb_x];
      bus.tap_2        <= lb_line[1][lb_x];
      bus.tap_3        <= lb_line[2][lb_x];
      lb_line[2][lb_x] <= lb_line[1][lb_x];
      lb_line[1][lb_x] <= lb_line[0][lb_x];
      lb_line[0][lb_x] <= bus.tap_0;
    end
  end

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output for the first n_consumed pixels of the frame in
  // raster order: one window per pixel whose 4x4 neighbourhood up and to
  // the left lies fully inside the image.
  task automatic push_expected(input int n_consumed, input bit complete);
    exp_t e;
    for (int p = 0; p < n_consumed; p++) begin
      int x = p % W;
      int y = p / W;
      if (x >= 3 && y >= 3) begin
        e.win = '0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            e.win[(r*4+c)*DW +: DW] = frame[y-3+r][x-3+c];
        e.x    = x - 3;
        e.y    = y - 3;
        e.last = complete && (p == W*H-1);
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_done && !bus.win_valid) begin
      total++;
      bad++;
      $display("FAIL frame_done_without_valid: got 1 required 0");
    end
    if (bus.frame_done) n_done++;
    if (bus.win_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window: got x=%0d y=%0d required none", bus.win_x, bus.win_y);
      end else begin
        e = q.pop_front();
        check("win", bus.win, e.win);
        check("win_xy", WB'({bus.win_x, bus.win_y}), WB'({3'(e.x), 3'(e.y)}));
        check("frame_done", WB'(bus.frame_done), WB'(e.last));
`ifdef WIN_FRAME_STATS_EN
        if (e.last) check("win_count", WB'(bus.win_count), WB'((W-3)*(H-3)));
`endif
      end
      if (cap_en) begin
        if (!have_first) cap_first = bus.win;
        have_first = 1'b1;
        cap_last   = bus.win;
        cap_last_x = int'(bus.win_x);
        cap_last_y = int'(bus.win_y);
        if (bus.win_x == 0 && bus.win_y == 1) cap_wrap = bus.win;
      end
    end
  end

  task automatic cyc_idle(input bit fl);
    @(negedge clk);
    bus.ce    = 1'b0;
    bus.sof   = 1'b0;
    bus.flush = fl;
  endtask

  task automatic cyc_px(input int x, input pixel_t v, input bit s, input bit fl);
    @(negedge clk);
    bus.ce    = 1'b1;
    bus.sof   = s;
    bus.flush = fl;
    bus.tap_0 = v;
    lb_x      = x;
  endtask

  task automatic run_frame(input bit det, input bit gaps, input bit flush_ce,
                           input int n_px, input bit do_flush);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame[y][x] = det ? pixel_t'(y*16 + x) : pixel_t'($urandom);
    push_expected(do_flush ? n_px : n_px - 1, do_flush && (n_px == W*H));
    for (int p = 0; p < n_px; p++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc_idle(1'b0);
      cyc_px(p % W, frame[p/W][p%W], p == 0, flush_ce && ($urandom_range(0, 1) == 1));
    end
    if (do_flush) cyc_idle(1'b1);
    repeat (4) cyc_idle(1'b0);
  endtask

  task automatic check_counts(input string name, input int v0, input int d0,
                              input int exp_v, input int exp_d);
    check({name, "_windows"}, WB'(n_valid - v0), WB'(exp_v));
    check({name, "_frame_done"}, WB'(n_done - d0), WB'(exp_d));
  endtask

  initial begin
    int v0, d0;
    bus.ce = 1'b0; bus.sof = 1'b0; bus.flush = 1'b0; bus.tap_0 = '0;
    repeat (3) @(negedge clk);
    check("rst_win_valid", WB'(bus.win_valid), '0);
    check("rst_win", bus.win, '0);
    check("rst_frame_done", WB'(bus.frame_done), '0);
    check("rst_win_xy", WB'({bus.win_x, bus.win_y}), '0);
    rst = 1'b1;

    // flush while idle, then a deterministic continuous frame
    v0 = n_valid; d0 = n_done;
    repeat (3) cyc_idle(1'b1);
    cap_en = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, W*H, 1'b1);
    cap_en = 1'b0;
    check_counts("det_frame", v0, d0, 15, 1);
    check("first_00", WB'(cap_first[0 +: DW]), WB'(8'h00));
    check("first_33", WB'(cap_first[15*DW +: DW]), WB'(8'h33));
    check("last_xy", WB'({cap_last_x, cap_last_y}), WB'({32'd4, 32'd2}));
    check("last_33", WB'(cap_last[15*DW +: DW]), WB'(8'h57));
    check("wrap_00", WB'(cap_wrap[0 +: DW]), WB'(8'h10));
    check("wrap_33", WB'(cap_wrap[15*DW +: DW]), WB'(8'h43));

    // stalled ce, deterministic and random contents
    v0 = n_valid; d0 = n_done;
    run_frame(1'b1, 1'b1, 1'b0, W*H, 1'b1);
    check_counts("gap_det", v0, d0, 15, 1);
    v0 = n_valid; d0 = n_done;
    run_frame(1'b0, 1'b1, 1'b0, W*H, 1'b1);
    check_counts("gap_rand", v0, d0, 15, 1);

    // flush asserted alongside ce
    v0 = n_valid; d0 = n_done;
    run_frame(1'b0, 1'b1, 1'b1, W*H, 1'b1);
    check_counts("flush_ce", v0, d0, 15, 1);

    // early restart where pixel (5,4) would arrive
    v0 = n_valid; d0 = n_done;
    run_frame(1'b1, 1'b0, 1'b0, 4*W + 5, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, W*H, 1'b1);
    check_counts("restart", v0, d0, 6 + 15, 1);

    // asynchronous reset mid-frame at (2,3)
    v0 = n_valid; d0 = n_done;
    run_frame(1'b1, 1'b0, 1'b0, 3*W + 2, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_win_valid", WB'(bus.win_valid), '0);
    check("arst_win", bus.win, '0);
    check("arst_frame_done", WB'(bus.frame_done), '0);
    check("arst_win_xy", WB'({bus.win_x, bus.win_y}), '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cyc_px(i % W, pixel_t'($urandom), 1'b0, 1'b0);
    cyc_idle(1'b1);
    repeat (3) cyc_idle(1'b0);
    check_counts("post_rst_nosof", v0, d0, 0, 0);
    run_frame(1'b0, 1'b0, 1'b0, W*H, 1'b1);
    check_counts("post_rst_frame", v0, d0, 15, 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", WB'(q.size()), '0);
    check("total_frame_done", WB'(n_done), WB'(6));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
